// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch PC redirect logic.
package mips_pkg;
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } redirect_state_t;

  localparam logic [31:0] PC_STEP            = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;
  localparam int          FLUSH_CNT_W        = 3;
endpackage

// File: rtl/redirect_fsm.sv
// RUN/FLUSH sequencer that holds the flush pulses for FLUSH_CYCLES cycles after a redirect.
import mips_pkg::*;

module redirect_fsm #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic take,
  output logic flush_if_id,
  output logic flush_id_ex
);
  localparam logic [FLUSH_CNT_W-1:0] CNT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  redirect_state_t state;
  logic [FLUSH_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (take) begin
            state       <= FLUSH;
            cnt         <= CNT_LOAD;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state       <= RUN;
            flush_if_id <= 1'b0;
            flush_id_ex <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          flush_if_id <= 1'b0;
          flush_id_ex <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register and next-PC select with flush sequencing on taken branches.
// Optional taken-redirect counter enabled by defining REDIRECT_STATS_EN.
import mips_pkg::*;

module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic        branch_taken,
  input  logic [31:0] pc_branch_target,
  output logic [31:0] pc_if,
  output logic [31:0] pc_plus4,
  output logic        flush_if_id,
  output logic        flush_id_ex,
`ifdef REDIRECT_STATS_EN
  output logic [31:0] redirect_count,
`endif
  output logic        misalign_exc
);
  logic take;
  logic misaligned;

  // Flush outputs are high exactly while the sequencer is in FLUSH, so they double as its state.
  assign take       = branch_valid & branch_taken & ~flush_if_id;
  assign misaligned = |pc_branch_target[1:0];
  assign pc_plus4   = pc_if + PC_STEP;

  redirect_fsm #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .take       (take),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_if        <= RESET_PC;
      misalign_exc <= 1'b0;
    end else begin
      misalign_exc <= take & misaligned;
      if (take && misaligned) begin
        pc_if <= EXC_VECTOR;
      end else if (take) begin
        pc_if <= pc_branch_target;
      end else if (!stall) begin
        pc_if <= pc_plus4;
      end
    end
  end

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_count <= '0;
    end else if (take && (redirect_count != 32'hFFFF_FFFF)) begin
      redirect_count <= redirect_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed self-checking bench for pc_redirect_unit (default parameters).
`timescale 1ns/1ps
module tb_pc_redirect_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] pc_branch_target;
  logic [31:0] pc_if;
  logic [31:0] pc_plus4;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_exc;
`ifdef REDIRECT_STATS_EN
  logic [31:0] redirect_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  pc_redirect_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .branch_valid    (branch_valid),
    .branch_taken    (branch_taken),
    .pc_branch_target(pc_branch_target),
    .pc_if           (pc_if),
    .pc_plus4        (pc_plus4),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
`ifdef REDIRECT_STATS_EN
    .redirect_count  (redirect_count),
`endif
    .misalign_exc    (misalign_exc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic v, input logic t, input logic [31:0] tgt);
    branch_valid     = v;
    branch_taken     = t;
    pc_branch_target = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch(1'b0, 1'b0, 32'h0);
    step();
    tests_run++; if (pc_if !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want %h", pc_if, 32'h0); end
    tests_run++; if ({flush_if_id, flush_id_ex, misalign_exc} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {flush_if_id, flush_id_ex, misalign_exc}); end
`ifdef REDIRECT_STATS_EN
    tests_run++; if (redirect_count !== 32'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", redirect_count); end
`endif
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests_run++; if (pc_if !== 32'(4 * i)) begin tests_failed++; $display("FAIL seq_pc%0d got %h want %h", i, pc_if, 32'(4 * i)); end
      tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin tests_failed++; $display("FAIL seq_flush%0d got %b want 00", i, {flush_if_id, flush_id_ex}); end
    end
  endtask

  task automatic test_stall();
    step();
    tests_run++; if (pc_if !== 32'h10) begin tests_failed++; $display("FAIL stall_pre got %h want 00000010", pc_if); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++; if (pc_if !== 32'h10) begin tests_failed++; $display("FAIL stall_hold%0d got %h want 00000010", i, pc_if); end
    end
    stall = 1'b0;
    step();
    tests_run++; if (pc_if !== 32'h14) begin tests_failed++; $display("FAIL stall_release got %h want 00000014", pc_if); end
  endtask

  task automatic test_redirect();
    step(); step(); step();
    tests_run++; if (pc_if !== 32'h20) begin tests_failed++; $display("FAIL redir_pre got %h want 00000020", pc_if); end
    branch(1'b1, 1'b1, 32'h100);
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'h100) begin tests_failed++; $display("FAIL redir_pc got %h want 00000100", pc_if); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin tests_failed++; $display("FAIL redir_flush0 got %b want 11", {flush_if_id, flush_id_ex}); end
    tests_run++; if (misalign_exc !== 1'b0) begin tests_failed++; $display("FAIL redir_noexc got %b want 0", misalign_exc); end
    step();
    tests_run++; if (pc_if !== 32'h104) begin tests_failed++; $display("FAIL redir_pc1 got %h want 00000104", pc_if); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin tests_failed++; $display("FAIL redir_flush1 got %b want 11", {flush_if_id, flush_id_ex}); end
    step();
    tests_run++; if (pc_if !== 32'h108) begin tests_failed++; $display("FAIL redir_pc2 got %h want 00000108", pc_if); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin tests_failed++; $display("FAIL redir_flush2 got %b want 00", {flush_if_id, flush_id_ex}); end
  endtask

  task automatic test_redirect_over_stall();
    stall = 1'b1;
    branch(1'b1, 1'b1, 32'h200);
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'h200) begin tests_failed++; $display("FAIL stallredir_pc got %h want 00000200", pc_if); end
    tests_run++; if (flush_if_id !== 1'b1) begin tests_failed++; $display("FAIL stallredir_flush got %b want 1", flush_if_id); end
    step();
    tests_run++; if (pc_if !== 32'h200) begin tests_failed++; $display("FAIL stallredir_hold got %h want 00000200", pc_if); end
    tests_run++; if (flush_id_ex !== 1'b1) begin tests_failed++; $display("FAIL stallredir_flush1 got %b want 1", flush_id_ex); end
    stall = 1'b0;
    step();
    tests_run++; if (pc_if !== 32'h204) begin tests_failed++; $display("FAIL stallredir_pc2 got %h want 00000204", pc_if); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin tests_failed++; $display("FAIL stallredir_flush2 got %b want 00", {flush_if_id, flush_id_ex}); end
  endtask

  task automatic test_ignore_in_flush();
    branch(1'b1, 1'b1, 32'h400);
    step();
    tests_run++; if (pc_if !== 32'h400) begin tests_failed++; $display("FAIL ign_redir got %h want 00000400", pc_if); end
    branch(1'b1, 1'b1, 32'h300);
    step();
    tests_run++; if (pc_if !== 32'h404) begin tests_failed++; $display("FAIL ign_pc1 got %h want 00000404", pc_if); end
    tests_run++; if (flush_if_id !== 1'b1) begin tests_failed++; $display("FAIL ign_flush1 got %b want 1", flush_if_id); end
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'h408) begin tests_failed++; $display("FAIL ign_pc2 got %h want 00000408", pc_if); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin tests_failed++; $display("FAIL ign_flush2 got %b want 00", {flush_if_id, flush_id_ex}); end
  endtask

  task automatic test_not_taken();
    branch(1'b1, 1'b0, 32'h500);
    step();
    tests_run++; if (pc_if !== 32'h40C) begin tests_failed++; $display("FAIL nt_pc got %h want 0000040c", pc_if); end
    tests_run++; if (flush_if_id !== 1'b0) begin tests_failed++; $display("FAIL nt_flush got %b want 0", flush_if_id); end
    branch(1'b1, 1'b0, 32'h502);
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'h410) begin tests_failed++; $display("FAIL nt_mis_pc got %h want 00000410", pc_if); end
    tests_run++; if (misalign_exc !== 1'b0) begin tests_failed++; $display("FAIL nt_mis_exc got %b want 0", misalign_exc); end
  endtask

  task automatic test_misalign();
    branch(1'b1, 1'b1, 32'h102);
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'h80) begin tests_failed++; $display("FAIL mis_pc got %h want 00000080", pc_if); end
    tests_run++; if (misalign_exc !== 1'b1) begin tests_failed++; $display("FAIL mis_exc got %b want 1", misalign_exc); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin tests_failed++; $display("FAIL mis_flush got %b want 11", {flush_if_id, flush_id_ex}); end
    step();
    tests_run++; if (pc_if !== 32'h84) begin tests_failed++; $display("FAIL mis_pc1 got %h want 00000084", pc_if); end
    tests_run++; if (misalign_exc !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse got %b want 0", misalign_exc); end
    tests_run++; if (flush_if_id !== 1'b1) begin tests_failed++; $display("FAIL mis_flush1 got %b want 1", flush_if_id); end
    step();
    tests_run++; if (flush_if_id !== 1'b0) begin tests_failed++; $display("FAIL mis_flush2 got %b want 0", flush_if_id); end
  endtask

  task automatic test_wrap();
    branch(1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL wrap_pc got %h want fffffffc", pc_if); end
    tests_run++; if (pc_plus4 !== 32'h0) begin tests_failed++; $display("FAIL wrap_plus4 got %h want 00000000", pc_plus4); end
    step();
    tests_run++; if (pc_if !== 32'h0) begin tests_failed++; $display("FAIL wrap_pc1 got %h want 00000000", pc_if); end
    tests_run++; if (misalign_exc !== 1'b0) begin tests_failed++; $display("FAIL wrap_exc got %b want 0", misalign_exc); end
    step();
    tests_run++; if (pc_if !== 32'h4) begin tests_failed++; $display("FAIL wrap_pc2 got %h want 00000004", pc_if); end
    tests_run++; if (flush_if_id !== 1'b0) begin tests_failed++; $display("FAIL wrap_flush got %b want 0", flush_if_id); end
  endtask

  task automatic test_reset_mid_flush();
    branch(1'b1, 1'b1, 32'h600);
    step();
    branch(1'b0, 1'b0, 32'h0);
    step();
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b11) begin tests_failed++; $display("FAIL rmf_flush_pre got %b want 11", {flush_if_id, flush_id_ex}); end
`ifdef REDIRECT_STATS_EN
    tests_run++; if (redirect_count !== 32'd6) begin tests_failed++; $display("FAIL stats_count got %0d want 6", redirect_count); end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++; if (pc_if !== 32'h0) begin tests_failed++; $display("FAIL rmf_pc got %h want 00000000", pc_if); end
    tests_run++; if ({flush_if_id, flush_id_ex} !== 2'b00) begin tests_failed++; $display("FAIL rmf_flush got %b want 00", {flush_if_id, flush_id_ex}); end
`ifdef REDIRECT_STATS_EN
    tests_run++; if (redirect_count !== 32'd0) begin tests_failed++; $display("FAIL stats_clear got %0d want 0", redirect_count); end
`endif
    step();
    tests_run++; if (pc_if !== 32'h4) begin tests_failed++; $display("FAIL rmf_pc1 got %h want 00000004", pc_if); end
    branch(1'b1, 1'b1, 32'h700);
    step();
    branch(1'b0, 1'b0, 32'h0);
    tests_run++; if (pc_if !== 32'h700) begin tests_failed++; $display("FAIL rmf_redir got %h want 00000700", pc_if); end
    tests_run++; if (flush_if_id !== 1'b1) begin tests_failed++; $display("FAIL rmf_redir_flush got %b want 1", flush_if_id); end
`ifdef REDIRECT_STATS_EN
    tests_run++; if (redirect_count !== 32'd1) begin tests_failed++; $display("FAIL stats_after got %0d want 1", redirect_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_over_stall();
    test_ignore_in_flush();
    test_not_taken();
    test_misalign();
    test_wrap();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
